ni_req_packetizer: RTL

- Request-side packetizer of the network interface.
- Accepts one memory request (address, data, routing fields) over a valid/ready handshake and builds the 6-flit request packet (head, 4 body, tail).
- Serializes the packet one 16-bit flit per accepted beat onto the router injection link.
- Sits directly upstream of the router input port; downstream depacketizers recover data using the body-flit layout defined here.

---
 rtl/ni_req_packetizer_if.sv | 32 +++
 rtl/ni_req_packetizer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ni_req_packetizer_if.sv
// Request and flit-link signal bundle for the NI request packetizer.
// The master modport drives requests and flit_ready; the slave modport is the packetizer.
interface ni_req_packetizer_if #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FLIT_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [3:0]            req_dest;
  logic [3:0]            req_src;
  logic [2:0]            req_mode;
  logic [1:0]            req_flags;
  logic [FLIT_WIDTH-1:0] flit_out;
  logic                  flit_valid;
  logic                  flit_ready;
  logic                  busy;

  modport master (
    output req_valid, req_addr, req_data, req_dest, req_src, req_mode, req_flags,
    output flit_ready,
    input  req_ready, flit_out, flit_valid, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_dest, req_src, req_mode, req_flags,
    input  flit_ready,
    output req_ready, flit_out, flit_valid, busy
  );
endinterface

// File: rtl/ni_req_packetizer.sv
// Captures one memory request and serializes it as a 6-flit packet
// (head, body3..body0, tail check word) onto the router injection link.
module ni_req_packetizer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned FLIT_WIDTH  = 16,
  parameter int unsigned TOTAL_FLITS = 6
) (
  input logic                clk,
  input logic                rst,
  ni_req_packetizer_if.slave bus
);

  localparam int unsigned BEAT_W    = 3;
  localparam int unsigned BODY_W    = FLIT_WIDTH - 1;
  localparam int unsigned LAST_BEAT = TOTAL_FLITS - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            dest_q, dest_d;
  logic [3:0]            src_q, src_d;
  logic [2:0]            mode_q, mode_d;
  logic [1:0]            flags_q, flags_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic                  flit_valid_q, flit_valid_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;

  // Flit for a given beat; body data_bits are 15 bits with bit 0 as body/tail marker.
  function automatic logic [FLIT_WIDTH-1:0] build_flit(
    input logic [BEAT_W-1:0]     beat,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] data,
    input logic [3:0]            dest,
    input logic [3:0]            src,
    input logic [2:0]            mode,
    input logic [1:0]            flags
  );
    logic [BODY_W-1:0] b3, b2, b1, b0;
    logic [FLIT_WIDTH-1:0] f;
    b3 = {data[1:0], 13'b0};
    b2 = data[16:2];
    b1 = data[31:17];
    b0 = {1'b0, addr};
    case (beat)
      3'd0:    f = {3'(TOTAL_FLITS), flags, mode, dest, src};
      3'd1:    f = {b3, 1'b0};
      3'd2:    f = {b2, 1'b0};
      3'd3:    f = {b1, 1'b0};
      3'd4:    f = {b0, 1'b0};
      default: f = {b3 ^ b2 ^ b1 ^ b0, 1'b1};
    endcase
    return f;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      dest_q       <= '0;
      src_q        <= '0;
      mode_q       <= '0;
      flags_q      <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      src_q        <= src_d;
      mode_q       <= mode_d;
      flags_q      <= flags_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and registered-output logic; flits are prepared one cycle ahead.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    data_d       = data_q;
    dest_d       = dest_q;
    src_d        = src_q;
    mode_d       = mode_q;
    flags_d      = flags_q;
    flit_d       = flit_q;
    flit_valid_d = flit_valid_q;
    req_ready_d  = req_ready_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d       = bus.req_addr;
          data_d       = bus.req_data;
          dest_d       = bus.req_dest;
          src_d        = bus.req_src;
          mode_d       = bus.req_mode;
          flags_d      = bus.req_flags;
          state_d      = SEND;
          beat_d       = '0;
          flit_d       = build_flit('0, bus.req_addr, bus.req_data, bus.req_dest,
                                    bus.req_src, bus.req_mode, bus.req_flags);
          flit_valid_d = 1'b1;
          req_ready_d  = 1'b0;
          busy_d       = 1'b1;
        end
      end
      SEND: begin
        if (flit_valid_q && bus.flit_ready) begin
          if (beat_q == BEAT_W'(LAST_BEAT)) begin
            state_d      = IDLE;
            beat_d       = '0;
            flit_d       = '0;
            flit_valid_d = 1'b0;
            req_ready_d  = 1'b1;
            busy_d       = 1'b0;
          end else begin
            beat_d = BEAT_W'(beat_q + BEAT_W'(1));
            flit_d = build_flit(BEAT_W'(beat_q + BEAT_W'(1)), addr_q, data_q, dest_q,
                                src_q, mode_q, flags_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.flit_out   = flit_q;
  assign bus.flit_valid = flit_valid_q;
  assign bus.busy       = busy_q;

endmodule
